ram_n: RTL

RAM_N -- requirements
Module: ram_n

---
 rtl/ram_n_pkg.sv | 14 +
 rtl/ram_n_register.sv | 31 +++
 rtl/ram_n.sv | 76 +++++++
 3 files changed

// File: rtl/ram_n_pkg.sv
// rtl/ram_n_pkg.sv - shared constants for the ram_n register-file memory
package ram_n_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_ADDR_W = 3;

    // Word count is always a full power of two, so every address is in range.
    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int DEFAULT_DEPTH = ram_depth(DEFAULT_ADDR_W);

endpackage

// File: rtl/ram_n_register.sv
// rtl/ram_n_register.sv - WIDTH-bit storage register with load and synchronous reset
module register_n
    import ram_n_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = load_i ? d_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ram_n.sv
// rtl/ram_n.sv - one-write two-read register-file memory with distinct-write counter
module ram_n
    import ram_n_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [ADDR_W:0]   wr_count
);

    localparam int DEPTH = ram_depth(ADDR_W);

    logic [DEPTH-1:0] wr_sel;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    always_comb begin
        wr_sel = '0;
        if (load) begin
            wr_sel[addr_w] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register_n #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .rst    (rst),
            .load_i (wr_sel[i]),
            .d_i    (in),
            .q_o    (word_q[i])
        );
    end

    // Only a first write to a word counts, so the count saturates at DEPTH naturally.
    always_comb begin
        written_d = written_q | wr_sel;
        count_d   = count_q;
        if (load && !written_q[addr_w]) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written_q <= '0;
            count_q   <= '0;
        end else begin
            written_q <= written_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_a == ADDR_W'(i)) out_a = word_q[i];
            if (addr_b == ADDR_W'(i)) out_b = word_q[i];
        end
    end

    assign wr_count = count_q;

endmodule
